vga_sync_gen: RTL and testbench

Timing generator and pixel output stage for the 640x480 VGA display path. Produces the pixel clock enable, horizontal/vertical counters, blanking and sync signals. It also produces the once-per-frame refresh tick that every sprite/logo generator consumes. It also gates and registers the merged 3-bit colour returned by those generators before driving the connector.

---
 rtl/vga_sync_gen.sv | 143 ++++++++++++++
 tb/tb_vga_sync_gen.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// -----------------------------------------------------------------------------
// vga_sync_gen
//
// Timing generator and pixel output stage for a VGA display path (640x480 at
// the default parameters). A system-clock divider produces the pixel enable.
// Horizontal and vertical counters walk the full raster. The block decodes
// blanking and the active-low syncs. It emits a once-per-frame refresh tick
// for the sprite/logo generators. It also gates and registers the colour they
// return before it reaches the connector.
//
// Ports:
//   clk        in   1   system clock, single domain
//   reset      in   1   synchronous, active-high reset
//   rgb_in     in   3   merged colour for the current (pix_x, pix_y)
//   p_tick     out  1   pixel enable, high one clk in every CLK_DIV
//   pix_x      out  10  horizontal counter, 0..H_TOTAL-1
//   pix_y      out  10  vertical counter, 0..V_TOTAL-1
//   video_on   out  1   high inside the visible window
//   refr_tick  out  1   one-clk pulse per frame at the start of vertical blank
//   hsync      out  1   horizontal sync, active-low, aligned with pix_x
//   vsync      out  1   vertical sync, active-low, aligned with pix_y
//   rgb        out  3   registered, blank-gated colour (one pixel behind)
// -----------------------------------------------------------------------------
module vga_sync_gen #(
  parameter int CLK_DIV   = 2,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] rgb_in,
  output logic       p_tick,
  output logic [9:0] pix_x,
  output logic [9:0] pix_y,
  output logic       video_on,
  output logic       refr_tick,
  output logic       hsync,
  output logic       vsync,
  output logic [2:0] rgb
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  // A one-bit divider is kept for CLK_DIV=1; it then stays at 0 and p_tick
  // is permanently high.
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [9:0] X_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] Y_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] X_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] Y_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] Y_REFR   = 10'(V_DISPLAY - 1);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);

  logic [DIV_W-1:0] r_div_cnt;
  logic [9:0]       r_pix_x;
  logic [9:0]       r_pix_y;
  logic             r_hsync;
  logic             r_vsync;
  logic [2:0]       r_rgb;

  logic             w_p_tick;
  logic             w_x_last;
  logic             w_y_last;
  logic             w_video_on;
  logic [9:0]       w_pix_x_next;
  logic [9:0]       w_pix_y_next;
  logic             w_hs_active;
  logic             w_vs_active;

  always_comb begin
    w_p_tick   = (r_div_cnt == DIV_LAST);
    w_x_last   = (r_pix_x == X_LAST);
    w_y_last   = (r_pix_y == Y_LAST);
    w_video_on = (r_pix_x < X_VIS) && (r_pix_y < Y_VIS);
  end

  // Next counter values. The syncs are decoded from these rather than from
  // the registers, so the registered syncs line up with pix_x/pix_y instead
  // of trailing them by a pixel.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    w_pix_x_next = r_pix_x;
    w_pix_y_next = r_pix_y;
    if (w_p_tick) begin
      w_pix_x_next = w_x_last ? 10'd0 : r_pix_x + 10'd1;
      if (w_x_last) begin
        w_pix_y_next = w_y_last ? 10'd0 : r_pix_y + 10'd1;
      end
    end
  end

  always_comb begin
    w_hs_active = (w_pix_x_next >= HS_FIRST) && (w_pix_x_next <= HS_LAST);
    w_vs_active = (w_pix_y_next >= VS_FIRST) && (w_pix_y_next <= VS_LAST);
  end

  // Reset wins over every increment: a reset mid-line abandons the line.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values regardless of statement order.
    if (reset) begin
      r_div_cnt <= '0;
      r_pix_x   <= '0;
      r_pix_y   <= '0;
      r_hsync   <= 1'b1;
      r_vsync   <= 1'b1;
      r_rgb     <= 3'b000;
    end else begin
      r_div_cnt <= w_p_tick ? '0 : r_div_cnt + DIV_W'(1);
      r_pix_x   <= w_pix_x_next;
      r_pix_y   <= w_pix_y_next;
      r_hsync   <= ~w_hs_active;
      r_vsync   <= ~w_vs_active;
      // Colour is captured once per pixel, blanked outside the visible area.
      if (w_p_tick) begin
        r_rgb <= w_video_on ? rgb_in : 3'b000;
      end
    end
  end

  assign p_tick    = w_p_tick;
  assign pix_x     = r_pix_x;
  assign pix_y     = r_pix_y;
  assign video_on  = w_video_on;
  assign refr_tick = w_p_tick && w_x_last && (r_pix_y == Y_REFR);
  assign hsync     = r_hsync;
  assign vsync     = r_vsync;
  assign rgb       = r_rgb;

endmodule

// File: tb/tb_vga_sync_gen.sv
// -----------------------------------------------------------------------------
// tb_vga_sync_gen
//
// Self-checking bench for vga_sync_gen, run on a reduced raster so full frames
// fit in a short simulation. The reference model derives every output from
// the number of clocks since reset: pixel index = clocks / CLK_DIV, and the
// raster position follows from that by division and modulo.
// -----------------------------------------------------------------------------
module tb_vga_sync_gen;

  localparam int CLK_DIV   = 2;
  localparam int H_DISPLAY = 64;
  localparam int H_FRONT   = 4;
  localparam int H_SYNC    = 8;
  localparam int H_BACK    = 4;
  localparam int V_DISPLAY = 48;
  localparam int V_FRONT   = 2;
  localparam int V_SYNC    = 2;
  localparam int V_BACK    = 3;

  localparam int H_TOTAL    = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL    = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int HS_START   = H_DISPLAY + H_FRONT;
  localparam int VS_START   = V_DISPLAY + V_FRONT;
  localparam int LINE_CLKS  = H_TOTAL * CLK_DIV;
  localparam int FRAME_CLKS = H_TOTAL * V_TOTAL * CLK_DIV;

  logic       clk;
  logic       reset;
  logic [2:0] rgb_in;
  logic       p_tick;
  logic [9:0] pix_x;
  logic [9:0] pix_y;
  logic       video_on;
  logic       refr_tick;
  logic       hsync;
  logic       vsync;
  logic [2:0] rgb;

  int n_checks = 0;
  int n_pass   = 0;

  // Model state: clocks since reset release, and the expected colour register.
  int         m_n;
  logic [2:0] m_rgb;

  vga_sync_gen #(
    .CLK_DIV  (CLK_DIV),
    .H_DISPLAY(H_DISPLAY),
    .H_FRONT  (H_FRONT),
    .H_SYNC   (H_SYNC),
    .H_BACK   (H_BACK),
    .V_DISPLAY(V_DISPLAY),
    .V_FRONT  (V_FRONT),
    .V_SYNC   (V_SYNC),
    .V_BACK   (V_BACK)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .rgb_in   (rgb_in),
    .p_tick   (p_tick),
    .pix_x    (pix_x),
    .pix_y    (pix_y),
    .video_on (video_on),
    .refr_tick(refr_tick),
    .hsync    (hsync),
    .vsync    (vsync),
    .rgb      (rgb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic int m_x();
    return (m_n / CLK_DIV) % H_TOTAL;
  endfunction

  function automatic int m_y();
    return ((m_n / CLK_DIV) / H_TOTAL) % V_TOTAL;
  endfunction

  function automatic bit m_ptick();
    return (m_n % CLK_DIV) == CLK_DIV - 1;
  endfunction

  function automatic bit m_vid();
    return (m_x() < H_DISPLAY) && (m_y() < V_DISPLAY);
  endfunction

  function automatic bit m_hs();
    return !((m_x() >= HS_START) && (m_x() < HS_START + H_SYNC));
  endfunction

  function automatic bit m_vs();
    return !((m_y() >= VS_START) && (m_y() < VS_START + V_SYNC));
  endfunction

  function automatic bit m_refr();
    return m_ptick() && (m_x() == H_TOTAL - 1) && (m_y() == V_DISPLAY - 1);
  endfunction

  // One clock: capture pre-edge inputs, advance the model, then wait 1 time
  // unit so DUT outputs are sampled away from the edge.
  task automatic clk_step();
    logic       pre_reset;
    logic [2:0] pre_rgb;
    bit         pre_tick;
    bit         pre_vid;
    pre_reset = reset;
    pre_rgb   = rgb_in;
    pre_tick  = m_ptick();
    pre_vid   = m_vid();
    @(posedge clk);
    if (pre_reset) begin
      m_n   = 0;
      m_rgb = 3'b000;
    end else begin
      if (pre_tick) m_rgb = pre_vid ? pre_rgb : 3'b000;
      m_n++;
    end
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset  = 1'b1;
    rgb_in = 3'b111;
    clk_step();
    clk_step();
    n_checks++;
    if ({pix_x, pix_y} !== 20'd0) $display("FAIL reset_xy: got x=%0d y=%0d, want 0 0", pix_x, pix_y);
    else n_pass++;
    n_checks++;
    if ({hsync, vsync} !== 2'b11) $display("FAIL reset_sync: got hs=%b vs=%b, want 1 1", hsync, vsync);
    else n_pass++;
    n_checks++;
    if (rgb !== 3'b000) $display("FAIL reset_rgb: got %b, want 000", rgb);
    else n_pass++;
    n_checks++;
    if ({p_tick, refr_tick, video_on} !== 3'b001)
      $display("FAIL reset_ticks: got p=%b r=%b v=%b, want 0 0 1", p_tick, refr_tick, video_on);
    else n_pass++;
    reset = 1'b0;
    clk_step();
    n_checks++;
    if ({p_tick, pix_x} !== {1'b1, 10'd0}) $display("FAIL first_ptick: got p=%b x=%0d, want 1 0", p_tick, pix_x);
    else n_pass++;
    clk_step();
    n_checks++;
    if ({p_tick, pix_x} !== {1'b0, 10'd1}) $display("FAIL first_step: got p=%b x=%0d, want 0 1", p_tick, pix_x);
    else n_pass++;
  endtask

  task automatic test_line();
    int   fall_x = -1;
    int   rise_x = -1;
    int   low_ticks = 0;
    int   bad = 0;
    logic prev_hs;
    apply_reset();
    for (int i = 0; i < LINE_CLKS; i++) begin
      prev_hs = hsync;
      clk_step();
      if ({hsync, p_tick, pix_x} !== {m_hs(), m_ptick(), 10'(m_x())}) begin
        bad++;
        if (bad <= 4)
          $display("FAIL line_cycle: got hs=%b p=%b x=%0d, want hs=%b p=%b x=%0d",
                   hsync, p_tick, pix_x, m_hs(), m_ptick(), m_x());
      end
      if (prev_hs && !hsync) fall_x = int'(pix_x);
      if (!prev_hs && hsync) rise_x = int'(pix_x);
      if (!hsync && p_tick) low_ticks++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL line_model: got %0d bad cycles, want 0", bad);
    else n_pass++;
    n_checks++;
    if (fall_x != HS_START) $display("FAIL hsync_fall: got x=%0d, want %0d", fall_x, HS_START);
    else n_pass++;
    n_checks++;
    if (rise_x != HS_START + H_SYNC) $display("FAIL hsync_rise: got x=%0d, want %0d", rise_x, HS_START + H_SYNC);
    else n_pass++;
    n_checks++;
    if (low_ticks != H_SYNC) $display("FAIL hsync_width: got %0d ticks, want %0d", low_ticks, H_SYNC);
    else n_pass++;
    n_checks++;
    if ({pix_x, pix_y} !== {10'd0, 10'd1}) $display("FAIL line_len: got x=%0d y=%0d, want 0 1", pix_x, pix_y);
    else n_pass++;
  endtask

  task automatic test_frame();
    logic [27:0] act;
    logic [27:0] exp;
    int          bad = 0;
    int          pulses = 0;
    int          first_at = -1;
    int          second_at = -1;
    int          vs_low = 0;
    int          wraps = 0;
    logic [9:0]  prev_x;
    logic [9:0]  prev_y;
    apply_reset();
    for (int i = 0; i < 2 * FRAME_CLKS + 4; i++) begin
      prev_x = pix_x;
      prev_y = pix_y;
      rgb_in = 3'($urandom);
      clk_step();
      act = {p_tick, refr_tick, video_on, hsync, vsync, rgb, pix_x, pix_y};
      exp = {m_ptick(), m_refr(), m_vid(), m_hs(), m_vs(), m_rgb, 10'(m_x()), 10'(m_y())};
      if (act !== exp) begin
        bad++;
        if (bad <= 4) $display("FAIL frame_cycle %0d: got %h, want %h", i, act, exp);
      end
      if (refr_tick) begin
        pulses++;
        if (pulses == 1) first_at = i;
        if (pulses == 2) second_at = i;
        n_checks++;
        if ({pix_x, pix_y} !== {10'(H_TOTAL - 1), 10'(V_DISPLAY - 1)})
          $display("FAIL refr_pos: got x=%0d y=%0d, want %0d %0d", pix_x, pix_y, H_TOTAL - 1, V_DISPLAY - 1);
        else n_pass++;
      end
      if (!vsync) vs_low++;
      if (prev_y == 10'(V_TOTAL - 1) && pix_y != prev_y) begin
        wraps++;
        n_checks++;
        if ({prev_x, pix_x, pix_y} !== {10'(H_TOTAL - 1), 10'd0, 10'd0})
          $display("FAIL wrap: got prev_x=%0d x=%0d y=%0d, want %0d 0 0", prev_x, pix_x, pix_y, H_TOTAL - 1);
        else n_pass++;
      end
    end
    n_checks++;
    if (bad != 0) $display("FAIL frame_model: got %0d bad cycles, want 0", bad);
    else n_pass++;
    n_checks++;
    if (pulses != 2) $display("FAIL refr_count: got %0d, want 2", pulses);
    else n_pass++;
    n_checks++;
    if (second_at - first_at != FRAME_CLKS)
      $display("FAIL refr_period: got %0d, want %0d", second_at - first_at, FRAME_CLKS);
    else n_pass++;
    n_checks++;
    if (vs_low != 2 * V_SYNC * LINE_CLKS) $display("FAIL vsync_width: got %0d, want %0d", vs_low, 2 * V_SYNC * LINE_CLKS);
    else n_pass++;
    n_checks++;
    if (wraps != 2) $display("FAIL wrap_count: got %0d, want 2", wraps);
    else n_pass++;
  endtask

  task automatic test_rgb_const();
    int bad_model = 0;
    int bad_vis   = 0;
    int bad_blank = 0;
    int seen_vis  = 0;
    apply_reset();
    rgb_in = 3'b101;
    for (int i = 0; i < FRAME_CLKS + LINE_CLKS; i++) begin
      clk_step();
      if (rgb !== m_rgb) bad_model++;
      // One pixel after (0,y) and after (H_DISPLAY-1,y): colour is visible.
      if (pix_y < 10'(V_DISPLAY) && (pix_x == 10'd1 || pix_x == 10'(H_DISPLAY))) begin
        seen_vis++;
        if (rgb !== 3'b101) bad_vis++;
      end
      // One pixel after H_DISPLAY, and every vertical-blank line: black.
      if (pix_x == 10'(H_DISPLAY + 1) || pix_y >= 10'(V_DISPLAY)) begin
        if (rgb !== 3'b000) bad_blank++;
      end
    end
    n_checks++;
    if (bad_model != 0) $display("FAIL rgb_model: got %0d bad cycles, want 0", bad_model);
    else n_pass++;
    n_checks++;
    if (bad_vis != 0 || seen_vis == 0) $display("FAIL rgb_visible: got %0d bad of %0d, want 0 bad", bad_vis, seen_vis);
    else n_pass++;
    n_checks++;
    if (bad_blank != 0) $display("FAIL rgb_blank: got %0d non-black, want 0", bad_blank);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    int   budget = FRAME_CLKS + 10;
    bit   found = 0;
    int   bad = 0;
    rgb_in = 3'b011;
    for (int i = 0; i < budget && !found; i++) begin
      clk_step();
      if (m_x() == HS_START + 2 && m_y() == 30) found = 1;
    end
    n_checks++;
    if (!found || hsync !== 1'b0 || {pix_x, pix_y} !== {10'(HS_START + 2), 10'd30})
      $display("FAIL mid_reach: got x=%0d y=%0d hs=%b, want %0d 30 0", pix_x, pix_y, hsync, HS_START + 2);
    else n_pass++;
    reset = 1'b1;
    clk_step();
    reset = 1'b0;
    n_checks++;
    if ({pix_x, pix_y, hsync, vsync, rgb, p_tick} !== {20'd0, 2'b11, 3'b000, 1'b0})
      $display("FAIL mid_reset: got x=%0d y=%0d hs=%b vs=%b rgb=%b p=%b, want 0 0 1 1 000 0",
               pix_x, pix_y, hsync, vsync, rgb, p_tick);
    else n_pass++;
    for (int i = 0; i < LINE_CLKS + 10; i++) begin
      rgb_in = 3'($urandom);
      clk_step();
      if ({p_tick, hsync, vsync, rgb, pix_x, pix_y} !==
          {m_ptick(), m_hs(), m_vs(), m_rgb, 10'(m_x()), 10'(m_y())}) bad++;
    end
    n_checks++;
    if (bad != 0) $display("FAIL mid_restart: got %0d bad cycles, want 0", bad);
    else n_pass++;
  endtask

  initial begin
    reset  = 1'b1;
    rgb_in = 3'b000;
    m_n    = 0;
    m_rgb  = 3'b000;
    test_reset();
    test_line();
    test_frame();
    test_rgb_const();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
